// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and alignment/byte-enable helpers for the MEM-stage load/store unit.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int MAX_WAIT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lane[0];
         SZ_WORD: return |lane;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 4'b0001 << lane;
         SZ_HALF: return 4'b0011 << {lane[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed data memory bus: request side driven by the load/store unit, ack/rdata by the memory.
interface mem_access_unit_if #(parameter int NBITS = 32);

   logic             mem_req;
   logic             mem_we;
   logic [NBITS-1:0] mem_addr;
   logic [NBITS-1:0] mem_wdata;
   logic [3:0]       mem_be;
   logic             mem_ack;
   logic [NBITS-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/load_extend.sv
// Little-endian lane select plus sign/zero extension of a loaded memory word; purely combinational.
module load_extend
   import mem_pkg::*;
#(
   parameter int NBITS = 32
) (
   input  logic [NBITS-1:0] word_i,
   input  logic [1:0]       lane_i,
   input  logic [1:0]       size_i,
   input  logic             unsigned_i,
   output logic [NBITS-1:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word_i[{lane_i, 3'b000} +: 8];
      half_v = word_i[{lane_i[1], 4'b0000} +: 16];
      case (size_i)
         SZ_BYTE: data_o = {{(NBITS-8){~unsigned_i & byte_v[7]}}, byte_v};
         SZ_HALF: data_o = {{(NBITS-16){~unsigned_i & half_v[15]}}, half_v};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE -> ACCESS (until ack or MAX_WAIT) -> DONE, min 3 cycles per access.
// Stalls the pipeline combinationally from the issue cycle until DONE; misaligned ops are dropped with a pulse.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int NBITS    = 32,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_valid,
   input  logic             i_read,
   input  logic             i_write,
   input  logic [1:0]       i_size,
   input  logic             i_unsigned,
   input  logic [NBITS-1:0] i_addr,
   input  logic [NBITS-1:0] i_wdata,
   output logic             o_stall,
   output logic [NBITS-1:0] o_rdata,
   output logic             o_rdata_valid,
   output logic             o_misaligned,
   output logic             o_timeout,
   mem_access_unit_if.master mem
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NBITS-1:0] addr_q, addr_d;
   logic [NBITS-1:0] wdata_q, wdata_d;
   logic [NBITS-1:0] rdata_q, rdata_d;
   logic [1:0]       size_q, size_d;
   logic [1:0]       lane_q, lane_d;
   logic             uns_q, uns_d;
   logic             we_q, we_d;
   logic [3:0]       be_q, be_d;
   logic             rvld_q, rvld_d;
   logic             mis_q, mis_d;
   logic             tmo_q, tmo_d;

   logic             op_present;
   logic             op_mis;
   logic [NBITS-1:0] st_data;
   logic [NBITS-1:0] ld_data;

   assign op_present = i_valid & (i_read | i_write);
   assign op_mis     = is_misaligned(i_size, i_addr[1:0]);

   always_comb begin
      case (i_size)
         SZ_BYTE: st_data = {(NBITS/8){i_wdata[7:0]}};
         SZ_HALF: st_data = {(NBITS/16){i_wdata[15:0]}};
         default: st_data = i_wdata;
      endcase
   end

   load_extend #(.NBITS(NBITS)) u_load_extend (
      .word_i     (mem.mem_rdata),
      .lane_i     (lane_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ld_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      size_d  = size_q;
      lane_d  = lane_q;
      uns_d   = uns_q;
      we_d    = we_q;
      be_d    = be_q;
      rvld_d  = 1'b0;
      mis_d   = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op_present) begin
               if (op_mis) begin
                  mis_d = 1'b1;
               end else begin
                  addr_d  = {i_addr[NBITS-1:2], 2'b00};
                  lane_d  = i_addr[1:0];
                  size_d  = i_size;
                  uns_d   = i_unsigned;
                  we_d    = i_write;
                  be_d    = i_write ? store_be(i_size, i_addr[1:0]) : 4'b1111;
                  wdata_d = st_data;
                  cnt_d   = '0;
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            // ack takes priority over a timeout landing in the same cycle
            if (mem.mem_ack) begin
               if (!we_q) begin
                  rdata_d = ld_data;
                  rvld_d  = 1'b1;
               end
               state_d = ST_DONE;
            end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
               tmo_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= SZ_BYTE;
         lane_q  <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         rvld_q  <= 1'b0;
         mis_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         uns_q   <= uns_d;
         we_q    <= we_d;
         be_q    <= be_d;
         rvld_q  <= rvld_d;
         mis_q   <= mis_d;
         tmo_q   <= tmo_d;
      end
   end

   // The issue-cycle stall term is combinational on the inputs, so keep it quiet while reset is held.
   assign o_stall = i_reset_n &
                    ((state_q == ST_ACCESS) | ((state_q == ST_IDLE) & op_present & ~op_mis));

   assign o_rdata       = rdata_q;
   assign o_rdata_valid = rvld_q;
   assign o_misaligned  = mis_q;
   assign o_timeout     = tmo_q;

   assign mem.mem_req   = (state_q == ST_ACCESS);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;

endmodule
